mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline types and widths for the memory stage
package mem_stage_pkg;

  localparam int RF_ZIP_W  = 6;
  localparam int FWD_ZIP_W = 7;

  typedef enum logic [1:0] {
    MS_EMPTY     = 2'd0,
    MS_WAIT_DATA = 2'd1,
    MS_READY     = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with data-response wait and result hold buffer
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 mem_allowin,
  input  logic                 exe_to_mem_valid,
  input  logic [31:0]          exe_pc,
  input  logic [31:0]          exe_alu_result,
  input  logic                 exe_res_from_mem,
  input  logic                 exe_mem_we,
  input  logic [RF_ZIP_W-1:0]  exe_rf_zip,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 wb_allowin,
  output logic                 mem_to_wb_valid,
  output logic [31:0]          mem_pc,
  output logic [RF_ZIP_W-1:0]  mem_rf_zip,
  output logic [31:0]          mem_final_result,
  output logic [FWD_ZIP_W-1:0] mem_fwd_zip
);

  mem_state_e          state_q;
  mem_state_e          state_d;
  logic [31:0]         pc_q;
  logic [31:0]         alu_result_q;
  logic [31:0]         hold_q;
  logic                res_from_mem_q;
  logic [RF_ZIP_W-1:0] rf_zip_q;

  logic mem_op;
  logic accept;
  logic ready_go;
  logic handoff;
  logic data_in;

  // data_ok only counts when an access is actually outstanding; stale pulses fall out here
  assign data_in         = (state_q == MS_WAIT_DATA) & data_sram_data_ok;
  assign ready_go        = (state_q == MS_READY) | data_in;
  assign mem_to_wb_valid = (state_q != MS_EMPTY) & ready_go;
  assign mem_allowin     = (state_q == MS_EMPTY) | (ready_go & wb_allowin);
  assign mem_op          = exe_res_from_mem | exe_mem_we;
  assign accept          = exe_to_mem_valid & mem_allowin;
  assign handoff         = mem_to_wb_valid & wb_allowin;

  // Next state: a new instruction wins over handoff so back-to-back flow has no bubble
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = mem_op ? MS_WAIT_DATA : MS_READY;
    end else if (handoff) begin
      state_d = MS_EMPTY;
    end else if (data_in) begin
      state_d = MS_READY;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the instruction fields when it enters the stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q           <= 32'd0;
      alu_result_q   <= 32'd0;
      res_from_mem_q <= 1'b0;
      rf_zip_q       <= '0;
    end else if (accept) begin
      pc_q           <= exe_pc;
      alu_result_q   <= exe_alu_result;
      res_from_mem_q <= exe_res_from_mem;
      rf_zip_q       <= exe_rf_zip;
    end
  end

  // Keep load data when WB stalls in the response cycle, since rdata is a one-cycle pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= 32'd0;
    end else if (data_in & ~wb_allowin) begin
      hold_q <= data_sram_rdata;
    end
  end

  // In the response cycle the load value bypasses the hold buffer
  assign mem_final_result = !res_from_mem_q             ? alu_result_q    :
                            (state_q == MS_WAIT_DATA)   ? data_sram_rdata : hold_q;

  assign mem_pc      = pc_q;
  assign mem_rf_zip  = rf_zip_q;
  assign mem_fwd_zip = {(state_q != MS_EMPTY) & rf_zip_q[RF_ZIP_W-1],
                        rf_zip_q[RF_ZIP_W-2:0], ready_go};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [31:0] exe_pc;
  logic [31:0] exe_alu_result;
  logic        exe_res_from_mem;
  logic        exe_mem_we;
  logic [5:0]  exe_rf_zip;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [5:0]  mem_rf_zip;
  logic [31:0] mem_final_result;
  logic [6:0]  mem_fwd_zip;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_allowin       (mem_allowin),
    .exe_to_mem_valid  (exe_to_mem_valid),
    .exe_pc            (exe_pc),
    .exe_alu_result    (exe_alu_result),
    .exe_res_from_mem  (exe_res_from_mem),
    .exe_mem_we        (exe_mem_we),
    .exe_rf_zip        (exe_rf_zip),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_pc            (mem_pc),
    .mem_rf_zip        (mem_rf_zip),
    .mem_final_result  (mem_final_result),
    .mem_fwd_zip       (mem_fwd_zip)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ev, ld, st;
    logic [31:0] pc, alu;
    logic [5:0]  zip;
    logic        dok;
    logic [31:0] rdata;
    logic        wb;
    logic        e_allow, e_valid;
    logic [31:0] e_pc, e_final;
    logic [6:0]  e_fwd;
  } vec_t;

  localparam int NV = 21;
  vec_t vec[NV];

  typedef struct {
    logic [31:0] pc, alu, data;
    logic [5:0]  zip;
    logic        ld, memop, resp;
  } inst_t;

  inst_t mq[$];
  inst_t h;
  inst_t n;
  logic  have, rdy;

  function automatic vec_t mk(input logic ev, ld, st, input logic [31:0] pc, alu,
                              input logic [5:0] zip, input logic dok, input logic [31:0] rdata,
                              input logic wb, e_allow, e_valid, input logic [31:0] e_pc, e_final,
                              input logic [6:0] e_fwd);
    vec_t v;
    v.ev = ev; v.ld = ld; v.st = st; v.pc = pc; v.alu = alu; v.zip = zip;
    v.dok = dok; v.rdata = rdata; v.wb = wb; v.e_allow = e_allow; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_final = e_final; v.e_fwd = e_fwd;
    return v;
  endfunction

  task automatic idle_inputs();
    exe_to_mem_valid  = 1'b0;
    exe_pc            = 32'd0;
    exe_alu_result    = 32'd0;
    exe_res_from_mem  = 1'b0;
    exe_mem_we        = 1'b0;
    exe_rf_zip        = 6'd0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    wb_allowin        = 1'b1;
  endtask

  initial begin
    // ALU op, then load with late data_ok, load with WB stall, back-to-back ALU, store
    vec[0]  = mk(1,0,0, 32'h100, 32'h1234, 6'h25, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h00);
    vec[1]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,1, 32'h100, 32'h1234,     7'h4B);
    vec[2]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h0A);
    vec[3]  = mk(1,1,0, 32'h104, 32'h2000, 6'h23, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h0A);
    vec[4]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 0,0, 32'h0,   32'h0,        7'h46);
    vec[5]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 0,0, 32'h0,   32'h0,        7'h46);
    vec[6]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 1, 32'hDEADBEEF, 1, 1,1, 32'h104, 32'hDEADBEEF, 7'h47);
    vec[7]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h06);
    vec[8]  = mk(1,1,0, 32'h108, 32'h3000, 6'h27, 0, 32'h0,        0, 1,0, 32'h0,   32'h0,        7'h06);
    vec[9]  = mk(0,0,0, 32'h0,   32'h0,    6'h00, 1, 32'hDEADBEEF, 0, 0,1, 32'h108, 32'hDEADBEEF, 7'h4F);
    vec[10] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        0, 0,1, 32'h108, 32'hDEADBEEF, 7'h4F);
    vec[11] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,1, 32'h108, 32'hDEADBEEF, 7'h4F);
    vec[12] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h0E);
    vec[13] = mk(1,0,0, 32'h200, 32'hA0,   6'h21, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h0E);
    vec[14] = mk(1,0,0, 32'h204, 32'hA4,   6'h22, 0, 32'h0,        1, 1,1, 32'h200, 32'hA0,       7'h43);
    vec[15] = mk(1,0,0, 32'h208, 32'hA8,   6'h23, 0, 32'h0,        1, 1,1, 32'h204, 32'hA4,       7'h45);
    vec[16] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,1, 32'h208, 32'hA8,       7'h47);
    vec[17] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h06);
    vec[18] = mk(1,0,1, 32'h300, 32'h4000, 6'h00, 0, 32'h0,        1, 1,0, 32'h0,   32'h0,        7'h06);
    vec[19] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 1, 32'h55,       1, 1,1, 32'h300, 32'h4000,     7'h01);
    vec[20] = mk(0,0,0, 32'h0,   32'h0,    6'h00, 1, 32'h77,       1, 1,0, 32'h0,   32'h0,        7'h00);

    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid",   mem_to_wb_valid,  0);
    chk("reset_allowin", mem_allowin,      1);
    chk("reset_pc",      mem_pc,           0);
    chk("reset_zip",     mem_rf_zip,       0);
    chk("reset_final",   mem_final_result, 0);
    chk("reset_fwd",     mem_fwd_zip,      0);
    @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      exe_to_mem_valid  = vec[i].ev;
      exe_res_from_mem  = vec[i].ld;
      exe_mem_we        = vec[i].st;
      exe_pc            = vec[i].pc;
      exe_alu_result    = vec[i].alu;
      exe_rf_zip        = vec[i].zip;
      data_sram_data_ok = vec[i].dok;
      data_sram_rdata   = vec[i].rdata;
      wb_allowin        = vec[i].wb;
      @(negedge clk);
      chk($sformatf("vec%0d_allowin", i), mem_allowin,     vec[i].e_allow);
      chk($sformatf("vec%0d_valid", i),   mem_to_wb_valid, vec[i].e_valid);
      chk($sformatf("vec%0d_fwd", i),     mem_fwd_zip,     vec[i].e_fwd);
      if (vec[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i),    mem_pc,           vec[i].e_pc);
        chk($sformatf("vec%0d_final", i), mem_final_result, vec[i].e_final);
      end
    end

    // Reset while a load waits, then a stale data_ok must be ignored
    @(posedge clk);
    #1;
    idle_inputs();
    exe_to_mem_valid = 1'b1;
    exe_res_from_mem = 1'b1;
    exe_pc           = 32'h500;
    exe_alu_result   = 32'h6000;
    exe_rf_zip       = 6'h2A;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("rst_wait_allowin", mem_allowin, 0);
    #1 resetn = 1'b0;
    #1;
    chk("rst_async_valid",   mem_to_wb_valid, 0);
    chk("rst_async_allowin", mem_allowin,     1);
    chk("rst_async_pc",      mem_pc,          0);
    chk("rst_async_fwd",     mem_fwd_zip,     0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stale_dok_valid",   mem_to_wb_valid, 0);
    chk("stale_dok_allowin", mem_allowin,     1);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("stale_dok_after_valid", mem_to_wb_valid, 0);
    chk("stale_dok_after_fwd",   mem_fwd_zip,     0);

    // Randomized traffic against a transaction-level model of the one-entry stage
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      int kind;
      @(posedge clk);
      #1;
      have = (mq.size() != 0);
      if (have) h = mq[0];
      kind              = $urandom_range(0, 2);
      exe_to_mem_valid  = ($urandom_range(0, 3) != 0);
      exe_res_from_mem  = (kind == 1);
      exe_mem_we        = (kind == 2);
      exe_pc            = $urandom;
      exe_alu_result    = $urandom;
      exe_rf_zip        = 6'($urandom);
      if (kind == 2) exe_rf_zip[5] = 1'b0;
      wb_allowin        = ($urandom_range(0, 3) != 0);
      data_sram_rdata   = $urandom;
      if (have && h.memop && !h.resp)
        data_sram_data_ok = ($urandom_range(0, 2) == 0);
      else
        data_sram_data_ok = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      rdy = have && (!h.memop || h.resp || data_sram_data_ok);
      chk("rnd_valid",   mem_to_wb_valid, rdy);
      chk("rnd_allowin", mem_allowin,     !have || (rdy && wb_allowin));
      if (have) chk("rnd_fwd", mem_fwd_zip, {h.zip, rdy});
      if (rdy) begin
        chk("rnd_pc",    mem_pc,     h.pc);
        chk("rnd_zip",   mem_rf_zip, h.zip);
        chk("rnd_final", mem_final_result,
            h.ld ? (h.resp ? h.data : data_sram_rdata) : h.alu);
      end
      if (rdy && wb_allowin) begin
        void'(mq.pop_front());
      end else if (have && h.memop && !h.resp && data_sram_data_ok) begin
        mq[0].resp = 1'b1;
        mq[0].data = data_sram_rdata;
      end
      if (exe_to_mem_valid && (!have || (rdy && wb_allowin))) begin
        n.pc    = exe_pc;
        n.alu   = exe_alu_result;
        n.zip   = exe_rf_zip;
        n.ld    = exe_res_from_mem;
        n.memop = exe_res_from_mem | exe_mem_we;
        n.resp  = 1'b0;
        n.data  = 32'd0;
        mq.push_back(n);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
